forward_round_engine: RTL and testbench

- Iterative encryption engine: the forward counterpart of the codebase's reverse (decryption) round.
- Each round applies substitutekey (forward S-box) -> diffusion (forward mix) -> addroundkey, one round per clock.
- Round keys are fetched through a request/valid handshake. The finished block is held under a valid/ready output handshake.
- Sits between the block source and the key schedule store. Its output feeds the ciphertext path and the decrypt-side round chain.

---
 rtl/forward_round_engine.sv | 121 ++++++++++++
 tb/tb_forward_round_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/forward_round_engine.sv
// forward_round_engine: iterative forward cipher, one S-box/shift/mix/addkey round per accepted key.
// Optional INITIAL_ADDKEY_EN inserts a WHITEN state that XORs round key 0 before the first round.
module forward_round_engine #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  output logic               key_req,
  output logic [CNT_W-1:0]   key_idx,
  input  logic               key_valid,
  input  logic [127:0]       key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0;
`ifdef INITIAL_ADDKEY_EN
  localparam logic [1:0] WHITEN = 2'd1;
`endif
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [1:0]       st;
  logic [127:0]     state_reg;
  logic [CNT_W-1:0] cnt;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Diffusion is a row rotation (row r left by r) followed by the column mix.
  function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = SBOX[s[8*i +: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[4*r+c] = b[4*r+((c+r)&3)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[c];
      a1 = t[4+c];
      a2 = t[8+c];
      a3 = t[12+c];
      o[8*c +: 8]      = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4+c) +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[8*(8+c) +: 8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[8*(12+c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o ^ k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      state_reg <= '0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          state_reg <= in_block;
          cnt <= CNT_W'(1);
`ifdef INITIAL_ADDKEY_EN
          st <= WHITEN;
`else
          st <= ROUND;
`endif
        end
`ifdef INITIAL_ADDKEY_EN
        WHITEN: if (key_valid) begin
          state_reg <= state_reg ^ key_in;
          st <= ROUND;
        end
`endif
        ROUND: if (key_valid) begin
          state_reg <= fwd_round(state_reg, key_in);
          if (cnt == CNT_W'(NUM_ROUNDS)) st <= DONE;
          else cnt <= cnt + CNT_W'(1);
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign in_ready = st == IDLE;
  assign busy = st != IDLE;
  assign out_valid = st == DONE;
  assign out_block = state_reg;
  assign key_idx = st == ROUND ? cnt : '0;
`ifdef INITIAL_ADDKEY_EN
  assign key_req = st == ROUND || st == WHITEN;
`else
  assign key_req = st == ROUND;
`endif
endmodule

// File: tb/tb_forward_round_engine.sv
// tb_forward_round_engine: randomized bench against a GF(2^8) arithmetic model of the forward/reverse rounds.
module tb_forward_round_engine;
  localparam int N = 10;
  localparam int W = 4;
`ifdef INITIAL_ADDKEY_EN
  localparam int WH = 1;
`else
  localparam int WH = 0;
`endif

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, kv = 0;
  logic [127:0] in_block = '0;
  logic in_ready, key_req, key_valid, out_valid, busy;
  logic [W-1:0] key_idx;
  logic [127:0] key_in, out_block;
  logic [127:0] keys [16];
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  int checks = 0, passed = 0, lat;
  logic [127:0] pt, base;

  assign key_valid = kv;
  assign key_in = keys[key_idx];
  always #5 clk = ~clk;

  forward_round_engine #(.NUM_ROUNDS(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .key_req(key_req), .key_idx(key_idx), .key_valid(key_valid), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] f_sub(input logic [127:0] s, input bit inv);
    for (int i = 0; i < 16; i++) s[8*i +: 8] = inv ? isbox[s[8*i +: 8]] : sbox[s[8*i +: 8]];
    return s;
  endfunction

  function automatic logic [127:0] f_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (inv) o[8*(4*r+(c+r)%4) +: 8] = s[8*(4*r+c) +: 8];
        else o[8*(4*r+c) +: 8] = s[8*(4*r+(c+r)%4) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] f_mix(input logic [127:0] s, input bit inv);
    logic [7:0] cf [4];
    logic [127:0] o = '0;
    cf[0] = inv ? 8'd14 : 8'd2;
    cf[1] = inv ? 8'd11 : 8'd3;
    cf[2] = inv ? 8'd13 : 8'd1;
    cf[3] = inv ? 8'd9 : 8'd1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[8*(4*r+c) +: 8] ^= gmul(cf[(j-r+4)%4], s[8*(4*j+c) +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] b, input bit wh);
    if (wh) b ^= keys[0];
    for (int r = 1; r <= N; r++) b = f_mix(f_shift(f_sub(b, 0), 0), 0) ^ keys[r];
    return b;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] b, input bit wh);
    for (int r = N; r >= 1; r--) b = f_sub(f_shift(f_mix(b ^ keys[r], 1), 1), 1);
    if (wh) b ^= keys[0];
    return b;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: keys always ready, 1: random key stalls, 2: three stalls at key 4
  task automatic run_block(input logic [127:0] blk, input int mode, output int l);
    int p, stalls, s4;
    logic [127:0] prev, exp;
    exp = ref_enc(blk, WH == 1);
    p = WH == 1 ? 0 : 1;
    stalls = 0;
    s4 = 0;
    l = 0;
    prev = '0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1;
    in_block = blk;
    @(posedge clk);
    #1 in_valid = 0;
    forever begin
      @(negedge clk);
      if (out_valid || l >= 200) break;
      check("key_req", key_req, 1);
      check("key_idx", key_idx, p);
      if (mode == 2 && key_idx == 4) begin
        if (s4 > 0) check("stall_hold", out_block, prev);
        prev = out_block;
        kv = s4 < 3 ? 1'b0 : 1'b1;
        if (s4 < 3) s4++;
      end else kv = mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!kv) stalls++;
      else p++;
      @(posedge clk);
      l++;
    end
    check("latency", l, N + WH + stalls);
    check("result", out_block, exp);
  endtask

  task automatic done_phase(input int hold);
    logic [127:0] held;
    held = out_block;
    for (int i = 0; i < hold; i++) begin
      check("done_valid", out_valid, 1);
      check("done_block", out_block, held);
      check("done_in_ready", in_ready, 0);
      check("done_busy", busy, 1);
      in_valid = i == 1;
      @(negedge clk);
    end
    in_valid = 0;
    check("done_hold_end", out_valid, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("idle_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic reset_mid_round();
    int n = 0;
    kv = 1;
    @(negedge clk);
    in_valid = 1;
    in_block = rnd128();
    @(posedge clk);
    #1 in_valid = 0;
    while (!(key_req && key_idx == 5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx5", key_idx, 5);
    rst = 1;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_key_req", key_req, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_block", out_block, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] y;
      y = 0;
      for (int z = 1; z < 256; z++) if (gmul(8'(x), 8'(z)) == 8'h01) y = 8'(z);
      sbox[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    for (int i = 0; i < 16; i++) keys[i] = rnd128() ^ 128'(i);
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_key_req", key_req, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_block", out_block, 0);
    check("reset_key_idx", key_idx, 0);
    @(negedge clk);
    rst = 0;

    pt = 128'h00112233445566778899aabbccddeeff;
    run_block(pt, 0, lat);
    base = out_block;
    check("round_trip", ref_dec(out_block, WH == 1), pt);
    done_phase(5);

    run_block(pt, 2, lat);
    check("stall_same_result", out_block, base);
    done_phase(1);

    reset_mid_round();
    run_block(rnd128(), 0, lat);
    done_phase(1);

    for (int t = 0; t < 4; t++) begin
      run_block(rnd128(), 1, lat);
      check("random_round_trip", ref_dec(out_block, WH == 1), in_block);
      done_phase($urandom_range(0, 3));
    end

    for (int i = 0; i < 16; i++) keys[i] = '0;
    run_block('0, 0, lat);
    done_phase(1);

`ifdef INITIAL_ADDKEY_EN
    for (int i = 1; i < 16; i++) keys[i] = rnd128();
    keys[0] = '1;
    pt = rnd128();
    run_block(pt, 0, lat);
    check("whiten_equals_inverted", out_block, ref_enc(~pt, 0));
    done_phase(1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
